top_if: RTL
===========

// Module: top_if
// PURPOSE
//   Instruction fetch stage of the MIPS pipeline. Holds the PC and a word-addressed
//   instruction memory that the debug unit loads. Fetches one instruction per advance
//   into the IF/ID latch. Drives the decode stage's instruction and PC+1 inputs, and
//   takes the decode stage's branch target and branch-taken flag back.
// PARAMETERS
//   LENGTH_INSTRUCTION  32            instruction width
//   CANT_BITS_ADDR      11            PC / memory address width (word address)
//   RAM_DEPTH           2048          instruction memory words (<= 2**CANT_BITS_ADDR)
//   HALT_INSTRUCTION    32'hFFFFFFFF  encoding that stops fetch
// PORTS
//   i_clock            in   1     clock, all state on posedge
//   i_soft_reset       in   1     asynchronous reset, active-high
//   i_enable_pipeline  in   1     global pipeline advance (debug step/continuous)
//   i_enable_etapa     in   1     stage enable from debug unit
//   i_stall            in   1     hazard-unit stall: PC and IF/ID hold
//   i_branch_control   in   1     branch/jump taken (from decode)
//   i_branch_dir       in   ADDR  branch/jump target word address (from decode)
//   i_prog_write       in   1     debug write strobe into instruction memory
//   i_prog_addr        in   ADDR  debug write address
//   i_prog_data        in   LEN   debug write data
//   i_start            in   1     leave IDLE and begin fetching at PC=0
//   o_instruction      out  LEN   IF/ID latched instruction
//   o_out_adder_pc     out  ADDR  IF/ID latched PC+1 of o_instruction
//   o_pc               out  ADDR  current PC (debug readout)
//   o_halt             out  1     halt instruction fetched; fetch stopped
// BEHAVIOUR
//   Reset (async): PC=0, o_instruction=0 (NOP), o_out_adder_pc=0, o_halt=0, state=IDLE.
//     Memory contents are not cleared by reset.
//   FSM: IDLE -> RUN on i_start. RUN -> HALTED when the fetched word == HALT_INSTRUCTION
//     on an advance. HALTED -> IDLE only by reset.
//   Programming: in IDLE, i_prog_write writes mem[i_prog_addr] <= i_prog_data on posedge.
//     Writes in RUN/HALTED are ignored. Addresses >= RAM_DEPTH are ignored.
//   advance = (state==RUN) & i_enable_pipeline & i_enable_etapa & ~i_stall.
//   On advance: o_instruction <= mem[PC]; o_out_adder_pc <= PC+1;
//     PC <= i_branch_control ? i_branch_dir : PC+1.
//   Latency: mem[PC] appears on o_instruction one posedge after PC holds that value.
//   Without advance: PC, o_instruction and o_out_adder_pc hold. A stall overrides a
//     branch; i_branch_control is sampled only on an advance.
//   PC+1 is modulo 2**CANT_BITS_ADDR: 0x7FF wraps to 0x000.
//     A fetch from address >= RAM_DEPTH returns 0.
//   Halt: the halt word itself is latched into o_instruction. From the same edge, o_halt=1
//     and the PC freezes. On later enabled cycles o_instruction <= 0 (drains as NOPs).
//   Reset mid-operation: immediate return to the reset values above. A partially loaded
//     program stays in memory.
// CONFIGURATION
//   BRANCH_FLUSH_EN defined: on an advance with i_branch_control=1, o_instruction <= 0
//     (NOP) instead of mem[PC]. o_out_adder_pc is still updated. No delay slot.
//   BRANCH_FLUSH_EN undefined: MIPS delay slot. The instruction at the old PC is latched
//     normally, then fetch continues at i_branch_dir.
// TESTING
//   1. Load mem[0..3]=0x20010005,0x20020003,0x00221820,0xFFFFFFFF; i_start; advance each
//      cycle -> o_instruction follows that sequence; o_out_adder_pc=1,2,3,4; o_halt=1 after
//      the 4th; then NOPs; PC stays 4.
//   2. Hold i_stall=1 for 3 cycles mid-program -> o_instruction, o_out_adder_pc and o_pc
//      unchanged; fetch resumes from the same PC after release.
//   3. At PC=5, i_branch_control=1, i_branch_dir=0x040 -> next o_pc=0x040.
//      With BRANCH_FLUSH_EN: o_instruction=0. Without it: o_instruction=mem[5].
//   4. Place PC at 0x7FF (jump to 0x7FF), advance -> o_out_adder_pc=0x000, o_pc=0x000.
//   5. i_prog_write during RUN to addr 2 with data 0xDEADBEEF -> mem[2] unchanged,
//      confirmed by a later fetch.
//   6. Assert i_soft_reset mid-run (between edges) -> outputs 0 and state IDLE at once;
//      i_start refetches the original program from PC=0.

Source files
------------

// File: rtl/top_if.sv
// Instruction fetch stage: PC, debug-loaded instruction memory and the IF/ID latch.
// Optional build macro BRANCH_FLUSH_EN squashes the fetched word on a taken branch (no delay slot).
module top_if #(
  parameter int                        LENGTH_INSTRUCTION = 32,
  parameter int                        CANT_BITS_ADDR     = 11,
  parameter int                        RAM_DEPTH          = 2048,
  parameter logic [LENGTH_INSTRUCTION-1:0] HALT_INSTRUCTION = 32'hFFFFFFFF
) (
  input  logic                          i_clock,
  input  logic                          i_soft_reset,
  input  logic                          i_enable_pipeline,
  input  logic                          i_enable_etapa,
  input  logic                          i_stall,
  input  logic                          i_branch_control,
  input  logic [CANT_BITS_ADDR-1:0]     i_branch_dir,
  input  logic                          i_prog_write,
  input  logic [CANT_BITS_ADDR-1:0]     i_prog_addr,
  input  logic [LENGTH_INSTRUCTION-1:0] i_prog_data,
  input  logic                          i_start,
  output logic [LENGTH_INSTRUCTION-1:0] o_instruction,
  output logic [CANT_BITS_ADDR-1:0]     o_out_adder_pc,
  output logic [CANT_BITS_ADDR-1:0]     o_pc,
  output logic                          o_halt
);

  // state      | meaning
  // ST_IDLE    | fetch stopped, debug unit may load instruction memory
  // ST_RUN     | fetching one word per advance
  // ST_HALTED  | halt word fetched, PC frozen, IF/ID drains NOPs until reset
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2
  } state_t;

  localparam logic [CANT_BITS_ADDR:0] DEPTH_L = (CANT_BITS_ADDR+1)'(RAM_DEPTH);

  state_t                          r_state;
  state_t                          w_state_next;
  logic [LENGTH_INSTRUCTION-1:0]   r_mem [RAM_DEPTH];
  logic [CANT_BITS_ADDR-1:0]       r_pc;
  logic [LENGTH_INSTRUCTION-1:0]   r_instruction;
  logic [CANT_BITS_ADDR-1:0]       r_adder_pc;
  logic                            r_halt;

  logic                            w_enabled;
  logic                            w_advance;
  logic [CANT_BITS_ADDR-1:0]       w_pc_plus1;
  logic                            w_pc_in_range;
  logic                            w_prog_in_range;
  logic [LENGTH_INSTRUCTION-1:0]   w_fetch_word;
  logic [LENGTH_INSTRUCTION-1:0]   w_fetch_latched;
  logic                            w_halt_fetch;

  assign w_enabled       = i_enable_pipeline & i_enable_etapa & ~i_stall;
  assign w_advance       = (r_state == ST_RUN) & w_enabled;
  assign w_pc_plus1      = r_pc + CANT_BITS_ADDR'(1);
  assign w_pc_in_range   = ({1'b0, r_pc} < DEPTH_L);
  assign w_prog_in_range = ({1'b0, i_prog_addr} < DEPTH_L);
  assign w_fetch_word    = w_pc_in_range ? r_mem[r_pc] : '0;

`ifdef BRANCH_FLUSH_EN
  // A squashed halt word never reaches decode, so it must not stop fetch either.
  assign w_fetch_latched = i_branch_control ? '0 : w_fetch_word;
  assign w_halt_fetch    = w_advance & ~i_branch_control & (w_fetch_word == HALT_INSTRUCTION);
`else
  assign w_fetch_latched = w_fetch_word;
  assign w_halt_fetch    = w_advance & (w_fetch_word == HALT_INSTRUCTION);
`endif

  always_ff @(posedge i_clock or posedge i_soft_reset) begin
    if (i_soft_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (i_start) w_state_next = ST_RUN;
      ST_RUN:    if (w_halt_fetch) w_state_next = ST_HALTED;
      ST_HALTED: w_state_next = ST_HALTED;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Memory is deliberately outside the reset domain so a loaded program survives a soft reset.
  always_ff @(posedge i_clock) begin
    if ((r_state == ST_IDLE) && i_prog_write && w_prog_in_range) begin
      r_mem[i_prog_addr] <= i_prog_data;
    end
  end

  always_ff @(posedge i_clock or posedge i_soft_reset) begin
    if (i_soft_reset) begin
      r_pc          <= '0;
      r_instruction <= '0;
      r_adder_pc    <= '0;
      r_halt        <= 1'b0;
    end else if (w_advance) begin
      r_instruction <= w_fetch_latched;
      r_adder_pc    <= w_pc_plus1;
      r_pc          <= i_branch_control ? i_branch_dir : w_pc_plus1;
      if (w_halt_fetch) begin
        r_halt <= 1'b1;
      end
    end else if ((r_state == ST_HALTED) && w_enabled) begin
      r_instruction <= '0;
    end
  end

  assign o_instruction  = r_instruction;
  assign o_out_adder_pc = r_adder_pc;
  assign o_pc           = r_pc;
  assign o_halt         = r_halt;

endmodule
